// File: rtl/serial_frame_ctrl_if.sv
// ============================================================================
// serial_frame_ctrl_if
// Byte handshake and serial status bundle for serial_frame_ctrl.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_frame_ctrl_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_line;
  logic       busy;
  logic [3:0] bit_sel;
  logic       bit_tick;
  logic       frame_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_line, busy, bit_sel, bit_tick, frame_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_line, busy, bit_sel, bit_tick, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/serial_frame_ctrl.sv
// ============================================================================
// serial_frame_ctrl
// Byte-to-serial frame sequencer (start, 8 data LSB first, stop) with bit timer.
// Optional even-parity slot enabled by macro SERIAL_FRAME_PARITY_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_frame_ctrl #(
  parameter int CLK_DIV = 12500000,
  parameter int DIV_W   = 24
) (
  input  wire                     clk_in,
  input  wire                     reset,
  serial_frame_ctrl_if.slave      bus
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_START = 3'd1;
  localparam logic [2:0] c_DATA  = 3'd2;
  localparam logic [2:0] c_STOP  = 3'd4;
`ifdef SERIAL_FRAME_PARITY_EN
  localparam logic [2:0] c_PARITY   = 3'd3;
  localparam logic [3:0] c_STOP_SEL = 4'd10;
`else
  localparam logic [3:0] c_STOP_SEL = 4'd9;
`endif
  localparam logic [3:0]       c_IDLE_SEL = 4'd15;
  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [2:0]       state_q,      state_d;
  logic [DIV_W-1:0] div_cnt_q,    div_cnt_d;
  logic [3:0]       bit_sel_q,    bit_sel_d;
  logic [7:0]       shadow_q,     shadow_d;
  logic             tx_line_q,    tx_line_d;
  logic             busy_q,       busy_d;
  logic             bit_tick_q,   bit_tick_d;
  logic             frame_done_q, frame_done_d;

  logic             w_tick;
  logic [2:0]       w_data_idx;

  assign w_tick     = (state_q != c_IDLE) && (div_cnt_q == c_DIV_LAST);
  assign w_data_idx = 3'(bit_sel_d - 4'd1);

  // State and output registers
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q      <= c_IDLE;
      div_cnt_q    <= '0;
      bit_sel_q    <= c_IDLE_SEL;
      shadow_q     <= 8'h00;
      tx_line_q    <= 1'b1;
      busy_q       <= 1'b0;
      bit_tick_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      bit_sel_q    <= bit_sel_d;
      shadow_q     <= shadow_d;
      tx_line_q    <= tx_line_d;
      busy_q       <= busy_d;
      bit_tick_q   <= bit_tick_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state: slot sequencing and bit timer
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_sel_d = bit_sel_q;
    shadow_d  = shadow_q;
    if (state_q == c_IDLE) begin
      div_cnt_d = '0;
      if (bus.tx_valid) begin
        shadow_d  = bus.tx_data;
        state_d   = c_START;
        bit_sel_d = 4'd0;
      end
    end else begin
      div_cnt_d = w_tick ? '0 : div_cnt_q + 1'b1;
      if (w_tick) begin
        case (state_q)
          c_START: begin
            state_d   = c_DATA;
            bit_sel_d = 4'd1;
          end
          c_DATA: begin
            if (bit_sel_q == 4'd8) begin
`ifdef SERIAL_FRAME_PARITY_EN
              state_d   = c_PARITY;
              bit_sel_d = 4'd9;
`else
              state_d   = c_STOP;
              bit_sel_d = c_STOP_SEL;
`endif
            end else begin
              bit_sel_d = bit_sel_q + 4'd1;
            end
          end
`ifdef SERIAL_FRAME_PARITY_EN
          c_PARITY: begin
            state_d   = c_STOP;
            bit_sel_d = c_STOP_SEL;
          end
`endif
          default: begin
            state_d   = c_IDLE;
            bit_sel_d = c_IDLE_SEL;
          end
        endcase
      end
    end
  end

  // Outputs are computed from the next state so they register in step with it
  always_comb begin
    tx_line_d    = 1'b1;
    case (state_d)
      c_START:  tx_line_d = 1'b0;
      c_DATA:   tx_line_d = shadow_d[w_data_idx];
`ifdef SERIAL_FRAME_PARITY_EN
      c_PARITY: tx_line_d = ^shadow_d;
`endif
      default:  tx_line_d = 1'b1;
    endcase
    busy_d       = (state_d != c_IDLE);
    bit_tick_d   = (state_d != c_IDLE) && (div_cnt_d == c_DIV_LAST);
    frame_done_d = (state_q == c_STOP) && (state_d == c_IDLE);
  end

  assign bus.tx_ready   = (state_q == c_IDLE);
  assign bus.tx_line    = tx_line_q;
  assign bus.busy       = busy_q;
  assign bus.bit_sel    = bit_sel_q;
  assign bus.bit_tick   = bit_tick_q;
  assign bus.frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_ctrl.sv
// ============================================================================
// tb_serial_frame_ctrl
// Randomized bench for serial_frame_ctrl against a slot/cycle reference model.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_frame_ctrl;

  localparam int DIV = 4;
`ifdef SERIAL_FRAME_PARITY_EN
  localparam int NSLOT = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int NSLOT = 10;
  localparam bit PAR   = 1'b0;
`endif
  localparam int FRAME_CYC = NSLOT * DIV;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;

  serial_frame_ctrl_if sif();

  serial_frame_ctrl #(.CLK_DIV(DIV), .DIV_W(24)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (sif)
  );

  always #5 clk_in = ~clk_in;

  int         n_checks = 0;
  int         n_errors = 0;
  // Model: m_n = cycles since accept edge (-1 when idle)
  int         m_n      = -1;
  logic [7:0] m_byte   = 8'h00;
  logic       m_done   = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic exp_line(input int n, input logic [7:0] b);
    int s;
    s = n / DIV;
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
    if (PAR && s == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk_in);
    if (!reset) begin
      m_n    = -1;
      m_done = 1'b0;
    end else if (m_n < 0) begin
      m_done = 1'b0;
      if (sif.tx_valid) begin
        m_n    = 0;
        m_byte = sif.tx_data;
      end
    end else begin
      m_n++;
      m_done = 1'b0;
      if (m_n == FRAME_CYC) begin
        m_n    = -1;
        m_done = 1'b1;
      end
    end
    #1;
    if (m_n < 0) begin
      check_val("tx_line",    sif.tx_line,    1);
      check_val("busy",       sif.busy,       0);
      check_val("bit_sel",    sif.bit_sel,    15);
      check_val("bit_tick",   sif.bit_tick,   0);
      check_val("tx_ready",   sif.tx_ready,   1);
      check_val("frame_done", sif.frame_done, m_done);
    end else begin
      check_val("tx_line",    sif.tx_line,    exp_line(m_n, m_byte));
      check_val("busy",       sif.busy,       1);
      check_val("bit_sel",    sif.bit_sel,    m_n / DIV);
      check_val("bit_tick",   sif.bit_tick,   (m_n % DIV) == DIV - 1);
      check_val("tx_ready",   sif.tx_ready,   0);
      check_val("frame_done", sif.frame_done, 0);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit keep_valid, output int k);
    k = 0;
    sif.tx_valid = 1'b1;
    sif.tx_data  = b;
    do begin
      step();
      k++;
    end while (m_n != 0 && k < 2 * FRAME_CYC + 4);
    check_val("accept_timeout", m_n == 0, 1);
    if (!keep_valid) sif.tx_valid = 1'b0;
    sif.tx_data = 8'($urandom);
  endtask

  task automatic finish_frame(input bit noisy);
    int k;
    k = 0;
    while (m_n >= 0 && k < FRAME_CYC + 4) begin
      if (noisy) begin
        sif.tx_valid = 1'($urandom % 2);
        sif.tx_data  = 8'($urandom);
      end
      step();
      k++;
    end
    sif.tx_valid = 1'b0;
    check_val("frame_end_timeout", m_n < 0, 1);
  endtask

  initial begin
    int k;
    sif.tx_valid = 1'b1;
    sif.tx_data  = 8'h55;
    reset        = 1'b0;
    repeat (3) step();

    reset = 1'b1;
    send_byte(8'hA5, 1'b0, k);
    check_val("first_accept_edge", k, 1);
    finish_frame(1'b1);
    step();

    // Back-to-back with valid held: one idle cycle between frames
    send_byte(8'h00, 1'b1, k);
    sif.tx_data = 8'hFF;
    k = 0;
    do begin
      step();
      k++;
    end while (m_n != 0 && k < 2 * FRAME_CYC);
    check_val("b2b_gap", k, FRAME_CYC + 1);
    check_val("b2b_byte", m_byte, 8'hFF);
    sif.tx_valid = 1'b0;
    finish_frame(1'b0);

    // Abort a frame during data bit 4
    send_byte(8'h81, 1'b0, k);
    k = 0;
    while (!(m_n >= 0 && m_n / DIV == 4) && k < FRAME_CYC) begin
      step();
      k++;
    end
    check_val("reach_bit4", sif.bit_sel, 4);
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    check_val("abort_no_done", sif.frame_done, 0);
    send_byte(8'h3C, 1'b0, k);
    finish_frame(1'b0);

    send_byte(8'h07, 1'b0, k);
    finish_frame(1'b0);
    send_byte(8'h03, 1'b0, k);
    finish_frame(1'b0);

    repeat (1500) begin
      sif.tx_valid = ($urandom % 3) == 0;
      sif.tx_data  = 8'($urandom);
      reset        = ($urandom % 150) != 0;
      step();
    end
    reset        = 1'b1;
    sif.tx_valid = 1'b0;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
